acc_arbiter: RTL and testbench

- Shares one 32-bit integer adder and N_ACC shared accumulator registers among N_CORE cores.
- Each core issues accumulate requests (index, operand) over a valid/ready handshake.
- Round-robin arbitration grants at most one request per cycle; the accepted operand goes through a 2-stage pipeline into the selected accumulator.
- Sits beside the global-counter logic in the multi-core top; the parent core clears the accumulators at fork and reads the results after join.

---
 rtl/acc_arbiter.sv | 159 +++++++++++++++
 tb/tb_acc_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_arbiter.sv
// acc_arbiter: round-robin sharing of one 32-bit adder and N_ACC accumulators
// among N_CORE requesting cores. Accepted requests go through a single
// operand stage, then the add is written into the selected accumulator.
module acc_arbiter #(
    parameter int N_CORE = 4,
    parameter int N_ACC  = 2,
    parameter int IDX_W  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [N_CORE-1:0]       req_valid,
    input  logic [N_CORE*IDX_W-1:0] req_idx,
    input  logic [N_CORE*32-1:0]    req_data,
    output logic [N_CORE-1:0]       req_ready,
    output logic [N_ACC*32-1:0]     acc_data,
    output logic                    idle,
    output logic                    idx_err
);

    localparam int PTR_W = (N_CORE > 1) ? $clog2(N_CORE) : 1;

    // Round-robin pointer: the core searched first this cycle.
    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;

    // Arbitration results.
    logic [PTR_W-1:0] cand [N_CORE];
    logic [N_CORE-1:0] cand_valid;
    logic              grant_any;
    logic [PTR_W-1:0]  grant_idx;
    logic              handshake;
    logic [IDX_W-1:0]  grant_req_idx;
    logic [31:0]       grant_req_data;

    // Operand stage between the handshake and the accumulator write.
    logic              s_valid_reg;
    logic [IDX_W-1:0]  s_idx_reg;
    logic [31:0]       s_data_reg;
    logic              s_in_range;

    // Accumulators and the single shared adder.
    logic [31:0]       acc_reg [N_ACC];
    logic [31:0]       acc_sel;
    logic [31:0]       add_sum;
    logic              idx_err_reg;

    // Candidate k is core (ptr + k) mod N_CORE; position 0 has highest priority.
    genvar gi;
    generate
        for (gi = 0; gi < N_CORE; gi++) begin : g_cand
            logic [PTR_W:0] sum;
            assign sum = {1'b0, ptr_reg} + (PTR_W+1)'(gi);
            assign cand[gi] = (sum >= (PTR_W+1)'(N_CORE))
                              ? PTR_W'(sum - (PTR_W+1)'(N_CORE))
                              : sum[PTR_W-1:0];
            assign cand_valid[gi] = req_valid[cand[gi]];
        end
    endgenerate

    // Pick the first valid candidate in search order.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = N_CORE - 1; k >= 0; k--) begin
            if (cand_valid[k]) begin
                grant_any = 1'b1;
                grant_idx = cand[k];
            end
        end
    end

    // Route the granted core's index and operand into the stage.
    always_comb begin
        grant_req_idx  = '0;
        grant_req_data = '0;
        for (int c = 0; c < N_CORE; c++) begin
            if (PTR_W'(c) == grant_idx) begin
                grant_req_idx  = req_idx[c*IDX_W +: IDX_W];
                grant_req_data = req_data[c*32 +: 32];
            end
        end
    end

    // Clear blocks every grant so nothing enters a pipeline being flushed.
    assign handshake = grant_any && !clear;
    assign req_ready = handshake ? (N_CORE'(1) << grant_idx) : '0;
    assign ptr_next  = (grant_idx == PTR_W'(N_CORE - 1)) ? '0 : grant_idx + 1'b1;

    // Pointer moves just past the core that completed a handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg <= '0;
        end else if (handshake) begin
            ptr_reg <= ptr_next;
        end
    end

    // Operand stage: capture on handshake; clear drops the in-flight op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_valid_reg <= 1'b0;
            s_idx_reg   <= '0;
            s_data_reg  <= '0;
        end else begin
            s_valid_reg <= handshake;
            if (handshake) begin
                s_idx_reg  <= grant_req_idx;
                s_data_reg <= grant_req_data;
            end
        end
    end

    assign s_in_range = (int'(s_idx_reg) < N_ACC);

    // Select the registered accumulator feeding the shared adder.
    always_comb begin
        acc_sel = '0;
        for (int k = 0; k < N_ACC; k++) begin
            if (int'(s_idx_reg) == k) begin
                acc_sel = acc_reg[k];
            end
        end
    end

    assign add_sum = acc_sel + s_data_reg;

    // Accumulator write-back; back-to-back ops see the already-updated value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_ACC; k++) acc_reg[k] <= '0;
        end else if (clear) begin
            for (int k = 0; k < N_ACC; k++) acc_reg[k] <= '0;
        end else if (s_valid_reg && s_in_range) begin
            for (int k = 0; k < N_ACC; k++) begin
                if (int'(s_idx_reg) == k) acc_reg[k] <= add_sum;
            end
        end
    end

    // Sticky flag for an accepted op that addressed a missing accumulator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_err_reg <= 1'b0;
        end else if (s_valid_reg && !s_in_range && !clear) begin
            idx_err_reg <= 1'b1;
        end
    end

    generate
        for (gi = 0; gi < N_ACC; gi++) begin : g_out
            assign acc_data[gi*32 +: 32] = acc_reg[gi];
        end
    endgenerate

    assign idle    = !s_valid_reg;
    assign idx_err = idx_err_reg;

endmodule

// File: tb/tb_acc_arbiter.sv
// Bench for acc_arbiter: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a queue-based model.
module tb_acc_arbiter;

    localparam int N_CORE = 4;
    localparam int N_ACC  = 3;
    localparam int IDX_W  = 2;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    clear = 1'b0;
    logic [N_CORE-1:0]       req_valid = '0;
    logic [N_CORE*IDX_W-1:0] req_idx = '0;
    logic [N_CORE*32-1:0]    req_data = '0;
    logic [N_CORE-1:0]       req_ready;
    logic [N_ACC*32-1:0]     acc_data;
    logic                    idle;
    logic                    idx_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    acc_arbiter #(.N_CORE(N_CORE), .N_ACC(N_ACC), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .req_valid(req_valid), .req_idx(req_idx), .req_data(req_data),
        .req_ready(req_ready), .acc_data(acc_data),
        .idle(idle), .idx_err(idx_err)
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        int          idx;
        logic [31:0] data;
    } op_t;

    int          ptr_m = 0;
    logic [31:0] acc_m [N_ACC];
    bit          err_m = 1'b0;
    op_t         pend [$];
    op_t         m_op;
    int          m_g;

    // First core at or after the pointer (cyclically) that is asking.
    function automatic int exp_grant();
        int c;
        for (int k = 0; k < N_CORE; k++) begin
            c = (ptr_m + k) % N_CORE;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_m = 0;
            err_m = 1'b0;
            pend.delete();
            for (int k = 0; k < N_ACC; k++) acc_m[k] = '0;
        end else if (clear) begin
            for (int k = 0; k < N_ACC; k++) acc_m[k] = '0;
            pend.delete();
        end else begin
            while (pend.size() > 0) begin
                m_op = pend.pop_front();
                if (m_op.idx < N_ACC) acc_m[m_op.idx] = acc_m[m_op.idx] + m_op.data;
                else err_m = 1'b1;
            end
            m_g = exp_grant();
            if (m_g >= 0) begin
                m_op.idx  = int'(req_idx[m_g*IDX_W +: IDX_W]);
                m_op.data = req_data[m_g*32 +: 32];
                pend.push_back(m_op);
                ptr_m = (m_g + 1) % N_CORE;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin : compare
        int          g;
        logic [3:0]  er;
        g  = exp_grant();
        er = (clear || g < 0) ? 4'b0 : 4'(1 << g);
        chk("req_ready", 32'(req_ready), 32'(er));
        for (int k = 0; k < N_ACC; k++)
            chk($sformatf("acc%0d", k), acc_data[k*32 +: 32], acc_m[k]);
        chk("idle", 32'(idle), 32'(pend.size() == 0));
        chk("idx_err", 32'(idx_err), 32'(err_m));
        if (|(req_valid & req_ready))
            $display("txn core=%0d idx=%0d data=%h", g, req_idx[g*IDX_W +: IDX_W], req_data[g*32 +: 32]);
    end

    // ---------------- stimulus helpers ----------------
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic set_req(input int c, input bit v, input int idx, input logic [31:0] d);
        req_valid[c]              = v;
        req_idx[c*IDX_W +: IDX_W] = IDX_W'(idx);
        req_data[c*32 +: 32]      = d;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        clear     = 1'b0;
        req_valid = '0;
        next();
        next();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] acc_of(input int k);
        return acc_data[k*32 +: 32];
    endfunction

    initial begin
        next();
        next();
        reset = 1'b0;

        // reset state
        neg();
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_err", 32'(idx_err), 32'd0);
        chk("rst_acc1", acc_of(1), 32'd0);
        next();

        // single request from core 2
        set_req(2, 1, 1, 32'd5);
        neg(); chk("single_ready", 32'(req_ready), 32'b0100); chk("single_idle0", 32'(idle), 32'd1);
        next();
        req_valid = '0;
        neg(); chk("single_busy", 32'(idle), 32'd0); chk("single_acc_early", acc_of(1), 32'd0);
        next();
        neg(); chk("single_acc", acc_of(1), 32'd5); chk("single_idle2", 32'(idle), 32'd1);
        next();

        // round-robin fairness from ptr = 0
        do_reset();
        for (int c = 0; c < N_CORE; c++) set_req(c, 1, 0, 32'd1);
        for (int i = 0; i < 8; i++) begin
            neg(); chk($sformatf("rr_grant%0d", i), 32'(req_ready), 32'(1 << (i % 4)));
            next();
        end
        req_valid = '0;
        neg(); chk("rr_acc_t1", acc_of(0), 32'd7);
        next();
        neg(); chk("rr_acc", acc_of(0), 32'd8);
        next();

        // same-index back-to-back: 7, -1, 10
        clear = 1'b1;
        next();
        clear = 1'b0;
        set_req(0, 1, 0, 32'd7);
        neg(); chk("b2b_ready", 32'(req_ready), 32'b0001);
        next();
        set_req(0, 1, 0, 32'hFFFF_FFFF);
        neg(); chk("b2b_acc_c1", acc_of(0), 32'd0);
        next();
        set_req(0, 1, 0, 32'd10);
        neg(); chk("b2b_acc_7", acc_of(0), 32'd7);
        next();
        req_valid = '0;
        neg(); chk("b2b_acc_6", acc_of(0), 32'd6);
        next();
        neg(); chk("b2b_acc_16", acc_of(0), 32'd16);

        // wrap-around on acc1
        set_req(2, 1, 1, 32'h7FFF_FFFF);
        next();
        set_req(2, 1, 1, 32'd1);
        next();
        req_valid = '0;
        neg(); chk("wrap_pre", acc_of(1), 32'h7FFF_FFFF);
        next();
        neg(); chk("wrap_acc", acc_of(1), 32'h8000_0000);
        next();

        // clear collision
        set_req(1, 1, 0, 32'd100);
        neg(); chk("clr_ready_t", 32'(req_ready), 32'b0010);
        next();
        req_valid[1] = 1'b0;
        clear = 1'b1;
        set_req(3, 1, 2, 32'd50);
        neg(); chk("clr_ready_none", 32'(req_ready), 32'd0);
        next();
        clear = 1'b0;
        neg(); chk("clr_regrant", 32'(req_ready), 32'b1000);
        chk("clr_acc0", acc_of(0), 32'd0); chk("clr_acc1", acc_of(1), 32'd0);
        next();
        req_valid = '0;
        next();
        neg(); chk("clr_acc2", acc_of(2), 32'd50); chk("clr_acc0_after", acc_of(0), 32'd0);
        next();

        // out-of-range index
        set_req(1, 1, 3, 32'd9);
        neg(); chk("bad_ready", 32'(req_ready), 32'b0010);
        next();
        req_valid = '0;
        neg(); chk("bad_err_t1", 32'(idx_err), 32'd0);
        next();
        neg(); chk("bad_err_t2", 32'(idx_err), 32'd1); chk("bad_acc2", acc_of(2), 32'd50);
        next();
        clear = 1'b1;
        next();
        clear = 1'b0;
        neg(); chk("bad_err_clear", 32'(idx_err), 32'd1); chk("bad_acc2_clr", acc_of(2), 32'd0);
        next();
        do_reset();
        neg(); chk("bad_err_reset", 32'(idx_err), 32'd0);
        next();

        // reset with an op in flight
        set_req(0, 1, 1, 32'd5);
        next();
        do_reset();
        neg(); chk("midrst_acc1", acc_of(1), 32'd0); chk("midrst_idle", 32'(idle), 32'd1);
        next();

        // randomized traffic honouring the hold-until-ready rule
        for (int n = 0; n < 1500; n++) begin
            logic [N_CORE-1:0] rdy;
            bit                v;
            int                id;
            logic [31:0]       d;
            neg();
            rdy = req_ready;
            next();
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                clear = ($urandom_range(0, 24) == 0);
                for (int c = 0; c < N_CORE; c++) begin
                    if (req_valid[c] && !rdy[c]) begin
                        if ($urandom_range(0, 7) == 0) req_valid[c] = 1'b0;
                    end else begin
                        v  = ($urandom_range(0, 1) == 1);
                        id = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2));
                        d  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 100));
                        set_req(c, v, id, d);
                    end
                end
            end
        end
        clear     = 1'b0;
        req_valid = '0;
        next();
        next();
        neg();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
